swan256_stream_ctrl: RTL

Word-stream front/back end for the serial SWAN256 encryption core.
- Packs 32-bit input words into a 256-bit block.
- Drives the core's start/inp/key, waits for core ready, captures the 256-bit result.
- Serialises the result as 32-bit words with valid/ready handshakes.
- The input buffer fills the next block while the core runs and the output drains.

---
 rtl/swan_pkg.sv | 20 ++
 rtl/swan_word_packer.sv | 46 ++++
 rtl/swan256_stream_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/swan_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | swan_pkg : widths and compute-FSM encoding for swan256_stream_ctrl |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package swan_pkg;
  localparam int WORD_W     = 32;
  localparam int BLOCK_SIZE = 256;
  localparam int KEY_SIZE   = 256;
  localparam int WPB        = BLOCK_SIZE / WORD_W;
  localparam int CNT_W      = $clog2(WPB);

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_START = 2'd1,
    C_BUSY  = 2'd2,
    C_DONE  = 2'd3
  } cstate_t;
endpackage
`default_nettype wire

// File: rtl/swan_word_packer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | swan_word_packer : WORD_W -> BLOCK_SIZE shift/fill buffer          |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module swan_word_packer #(
  parameter int WORD_W     = 32,
  parameter int BLOCK_SIZE = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [WORD_W-1:0]     i_data,
  input  logic                  i_clear,
  output logic [BLOCK_SIZE-1:0] o_block,
  output logic                  o_full
);
  localparam int WPB   = BLOCK_SIZE / WORD_W;
  localparam int CNT_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WPB - 1);

  logic [BLOCK_SIZE-1:0] r_buf;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (i_push) begin
      r_cnt <= (r_cnt == c_last_idx) ? '0 : r_cnt + 1'b1;
      if (r_cnt == c_last_idx) r_full <= 1'b1;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  // Shifting in from the right leaves the first word in the top (leftmost) slot.
  always_ff @(posedge clk) begin
    if (i_push) r_buf <= {r_buf[BLOCK_SIZE-WORD_W-1:0], i_data};
  end

  assign o_block = r_buf;
  assign o_full  = r_full;
endmodule
`default_nettype wire

// File: rtl/swan256_stream_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | swan256_stream_ctrl : word-stream wrapper for the SWAN256 core     |
// | Optional CBC chaining when SWAN_CBC_EN is defined.      Rev 1.0    |
// +------------------------------------------------------------------+
module swan256_stream_ctrl import swan_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_key_load,
  input  logic [KEY_SIZE-1:0]   i_key_in,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [WORD_W-1:0]     i_s_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [WORD_W-1:0]     o_m_data,
  output logic                  o_m_last,
  output logic                  o_core_start,
  output logic [BLOCK_SIZE-1:0] o_core_inp,
  output logic [KEY_SIZE-1:0]   o_core_key,
  input  logic                  i_core_ready,
  input  logic [BLOCK_SIZE-1:0] i_core_out
`ifdef SWAN_CBC_EN
  ,
  input  logic                  i_iv_load,
  input  logic [BLOCK_SIZE-1:0] i_iv_in
`endif
);
  cstate_t               r_state, w_state_next;
  logic                  r_busy_first, r_live, w_start, w_capture;
  logic                  w_in_full, w_s_xfer, w_m_xfer;
  logic [BLOCK_SIZE-1:0] w_in_block, r_out_buf;
  logic [CNT_W-1:0]      r_out_cnt;
  logic                  r_out_full;
  logic [KEY_SIZE-1:0]   r_key;

  assign o_s_ready = r_live & ~w_in_full;
  assign w_s_xfer  = i_s_valid & o_s_ready;

  swan_word_packer #(.WORD_W(WORD_W), .BLOCK_SIZE(BLOCK_SIZE)) u_packer (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_s_xfer),
    .i_data  (i_s_data),
    .i_clear (w_start),
    .o_block (w_in_block),
    .o_full  (w_in_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= C_IDLE;
      r_busy_first <= 1'b0;
      r_live       <= 1'b0;
      r_key        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_busy_first <= (r_state == C_START);
      r_live       <= 1'b1;
      if (i_key_load) r_key <= i_key_in;
    end
  end

  // core_ready may still be stale in the first busy cycle, so it is masked there.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      C_IDLE:  if (w_in_full) w_state_next = C_START;
      C_START: begin
        w_start      = 1'b1;
        w_state_next = C_BUSY;
      end
      C_BUSY:  if (!r_busy_first && i_core_ready) w_state_next = C_DONE;
      C_DONE:  if (!r_out_full) begin
        w_capture    = 1'b1;
        w_state_next = C_IDLE;
      end
      default: w_state_next = C_IDLE;
    endcase
  end

  assign o_core_start = w_start;
  assign o_core_key   = r_key;

`ifdef SWAN_CBC_EN
  logic [BLOCK_SIZE-1:0] r_chain;
  always_ff @(posedge clk) begin
    if (!rst)           r_chain <= '0;
    else if (i_iv_load) r_chain <= i_iv_in;
    else if (w_capture) r_chain <= i_core_out;
  end
  assign o_core_inp = w_in_block ^ r_chain;
`else
  assign o_core_inp = w_in_block;
`endif

  assign o_m_valid = r_out_full;
  assign o_m_last  = r_out_full & (r_out_cnt == CNT_W'(WPB - 1));
  assign w_m_xfer  = r_out_full & i_m_ready;
  assign o_m_data  = r_out_buf[BLOCK_SIZE-1 -: WORD_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_full <= 1'b0;
      r_out_cnt  <= '0;
    end else if (w_capture) begin
      r_out_full <= 1'b1;
      r_out_cnt  <= '0;
    end else if (w_m_xfer) begin
      r_out_cnt <= r_out_cnt + 1'b1;
      if (o_m_last) r_out_full <= 1'b0;
    end
  end

  // Output words leave from the top slot; the buffer shifts left per transfer.
  always_ff @(posedge clk) begin
    if (w_capture)     r_out_buf <= i_core_out;
    else if (w_m_xfer) r_out_buf <= r_out_buf << WORD_W;
  end
endmodule
`default_nettype wire
